sopc_sim_ctrl: RTL and testbench
================================

# sopc_sim_ctrl

Parametrised simulation/bring-up controller that sits between the bench clock/reset and the SoPC. It sequences the core reset and counts run cycles against a timeout. It snoops each core channel's data-bus writes for a tohost-style completion word and reports pass, fail (with channel and code) or timeout. It replaces fixed-delay reset and fixed-time finish with a synthesizable, multi-channel state machine usable in simulation and on FPGA.

## Interface
- NUM_CH, 1: number of monitored core/data-bus channels (1..8)
- ADDR_W, 32: data-bus address width
- DATA_W, 32: data-bus write-data width (≥2)
- CNT_W, 32: width of cycle counter
- TOHOST_ADDR, 32'h0000_1000: completion mailbox address (ADDR_W bits)
- RST_CYCLES, 5: clk cycles core_rst_n is held low after rst deasserts (≥1)
- TIMEOUT, 100: run-cycle limit; 0 disables timeout
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ch_wr_en  in  NUM_CH  per-channel data-bus write strobe
- ch_wr_addr  in  NUM_CH*ADDR_W  per-channel write address, channel i at [i*ADDR_W +: ADDR_W]
- ch_wr_data  in  NUM_CH*DATA_W  per-channel write data, same packing
- core_rst_n  out  1  active-low reset to the SoPC
- ch_done  out  NUM_CH  channel has written pass word
- done  out  1  terminal state reached
- pass  out  1  all channels passed
- fail  out  1  some channel wrote a fail word
- timeout  out  1  TIMEOUT reached without result
- fail_ch  out  max(1,$clog2(NUM_CH))  index of failing channel
- fail_code  out  DATA_W-1  fail word bits [DATA_W-1:1]
- cycle_cnt  out  CNT_W  run cycles elapsed

## Operation
- States: HOLD, RUN, PASS, FAIL, TMO. rst forces HOLD; all outputs 0 (core_rst_n=0).
- HOLD: internal hold counter increments per clk; writes ignored. When counter reaches RST_CYCLES-1, go to RUN and set core_rst_n=1.
- RUN: cycle_cnt increments by 1 every cycle, saturating at all-ones. A completion write is wr_en=1, addr==TOHOST_ADDR, data[0]=1.
  - data==1: set ch_done[i]; repeat writes harmless.
  - data[0]=1 and data≠1: failing write.
  - data[0]=0, or other addresses: ignored.
- Per-cycle priority in RUN: failing write (lowest channel index wins; fail_ch/fail_code latched) → FAIL. Else, if ch_done including this cycle's writes is all ones → PASS. Else, if TIMEOUT≠0 and cycle_cnt==TIMEOUT-1 → TMO.
- Same-cycle events:
  - A fail on one channel and a pass on another → FAIL.
  - A pass completing all channels on the timeout cycle → PASS.
- PASS/FAIL/TMO are sticky until rst. done=1. The matching flag is 1 (pass/fail/timeout exactly one-hot). cycle_cnt and ch_done freeze. core_rst_n stays 1. Later writes are ignored.
- rst asserted mid-run: immediate return to HOLD; core_rst_n drops asynchronously; all status cleared.

## Timing
- All outputs registered; no combinational input→output paths.
- core_rst_n rises on the RST_CYCLES-th rising clk edge after rst deasserts.
- cycle_cnt reads 0 in the first RUN cycle. It reads k after k further edges.
- A completion write sampled at edge N is reflected in ch_done/done/pass/fail at edge N (visible after N); latency 1 cycle.
- Timeout: timeout rises on the edge where cycle_cnt would advance from TIMEOUT-1, i.e. TIMEOUT edges after entering RUN. cycle_cnt then holds TIMEOUT-1.

## Test plan
- Reset sequence: NUM_CH=1, RST_CYCLES=5. Release rst at t0 → core_rst_n=0 for 4 edges, 1 from 5th edge; cycle_cnt=0 then counts.
- Single pass: write addr 0x1000, data 0x1 at run cycle 20 → next cycle done=1, pass=1, ch_done=1, cycle_cnt frozen at 20.
- Fail code: write 0x1000, data 0x0000_0007 → fail=1, fail_code=3, fail_ch=0. Later 0x1 write ignored, pass stays 0.
- Multi-channel: NUM_CH=4. Channels 0,2,3 pass early, nothing on ch1 → pass=0, ch_done=4'b1101. Then ch1 writes 0x1 and ch3 writes 0x5 the same cycle → FAIL, fail_ch=3, fail_code=2.
- Timeout: TIMEOUT=100, no writes → timeout=1 after 100 run cycles, cycle_cnt=99. Separately, a pass on cycle 99 → PASS, not TMO. Decoy writes (addr 0x1004 data 1; addr 0x1000 data 0x2) → no effect.
- Mid-run reset: assert rst at run cycle 50 → core_rst_n=0 and all status 0 asynchronously. Release rst → HOLD sequence repeats.

Source files
------------

// File: rtl/sopc_sim_ctrl.sv
// Bring-up controller: sequences the core reset, counts run cycles and
// snoops each channel's tohost writes to report pass, fail or timeout.
module sopc_sim_ctrl #(
    parameter int NUM_CH = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h0000_1000,
    parameter int RST_CYCLES = 5,
    parameter int TIMEOUT    = 100,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_wr_en,
    input  logic [NUM_CH*ADDR_W-1:0] ch_wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
    output logic                     core_rst_n,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic                     timeout,
    output logic [CH_W-1:0]          fail_ch,
    output logic [DATA_W-2:0]        fail_code,
    output logic [CNT_W-1:0]         cycle_cnt
);

    localparam logic [2:0] S_HOLD = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_PASS = 3'd2;
    localparam logic [2:0] S_FAIL = 3'd3;
    localparam logic [2:0] S_TMO  = 3'd4;

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [2:0]        state_q;
    logic [HW-1:0]     hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] done_q;
    logic [CH_W-1:0]   fch_q;
    logic [DATA_W-2:0] fcode_q;

    logic [NUM_CH-1:0] pass_hit;
    logic [NUM_CH-1:0] fail_hit;
    logic [NUM_CH-1:0] done_nxt;
    logic [CH_W-1:0]   f_idx;
    logic [DATA_W-2:0] f_code;
    logic              tmo_hit;

    always_comb begin
        pass_hit = '0;
        fail_hit = '0;
        f_idx    = '0;
        f_code   = '0;
        // Scan downward so the lowest failing channel is the one kept.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_wr_en[i]
                && ch_wr_addr[i*ADDR_W +: ADDR_W] == TOHOST_ADDR
                && ch_wr_data[i*DATA_W]) begin
                if (ch_wr_data[i*DATA_W +: DATA_W] == DATA_W'(1)) begin
                    pass_hit[i] = 1'b1;
                end else begin
                    fail_hit[i] = 1'b1;
                    f_idx  = CH_W'(i);
                    f_code = ch_wr_data[i*DATA_W + 1 +: DATA_W - 1];
                end
            end
        end
    end

    assign done_nxt = done_q | pass_hit;
    assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HOLD;
            hold_q  <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            fch_q   <= '0;
            fcode_q <= '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q <= S_RUN;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (|fail_hit) begin
                        state_q <= S_FAIL;
                        fch_q   <= f_idx;
                        fcode_q <= f_code;
                    end else if (&done_nxt) begin
                        state_q <= S_PASS;
                        done_q  <= done_nxt;
                    end else if (tmo_hit) begin
                        state_q <= S_TMO;
                        done_q  <= done_nxt;
                    end else begin
                        done_q <= done_nxt;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_rst_n = (state_q != S_HOLD);
    assign pass       = (state_q == S_PASS);
    assign fail       = (state_q == S_FAIL);
    assign timeout    = (state_q == S_TMO);
    assign done       = pass | fail | timeout;
    assign ch_done    = done_q;
    assign fail_ch    = fch_q;
    assign fail_code  = fcode_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_sopc_sim_ctrl.sv
// Directed bench for sopc_sim_ctrl: single-channel and four-channel
// instances checked through an expected-value queue.
module tb_sopc_sim_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1;
    logic        en1;
    logic [31:0] addr1;
    logic [31:0] data1;
    logic        rstn1, done1, pass1, fail1, tmo1;
    logic [0:0]  chd1;
    logic [0:0]  fch1;
    logic [30:0] fcode1;
    logic [31:0] cnt1;

    logic         rst4;
    logic [3:0]   en4;
    logic [127:0] addr4;
    logic [127:0] data4;
    logic         rstn4, done4, pass4, fail4, tmo4;
    logic [3:0]   chd4;
    logic [1:0]   fch4;
    logic [30:0]  fcode4;
    logic [31:0]  cnt4;

    sopc_sim_ctrl #(
        .NUM_CH(1), .RST_CYCLES(5), .TIMEOUT(100)
    ) dut1 (
        .clk(clk), .rst(rst1),
        .ch_wr_en(en1), .ch_wr_addr(addr1), .ch_wr_data(data1),
        .core_rst_n(rstn1), .ch_done(chd1), .done(done1),
        .pass(pass1), .fail(fail1), .timeout(tmo1),
        .fail_ch(fch1), .fail_code(fcode1), .cycle_cnt(cnt1)
    );

    sopc_sim_ctrl #(
        .NUM_CH(4), .RST_CYCLES(5), .TIMEOUT(100)
    ) dut4 (
        .clk(clk), .rst(rst4),
        .ch_wr_en(en4), .ch_wr_addr(addr4), .ch_wr_data(data4),
        .core_rst_n(rstn4), .ch_done(chd4), .done(done4),
        .pass(pass4), .fail(fail4), .timeout(tmo4),
        .fail_ch(fch4), .fail_code(fcode4), .cycle_cnt(cnt4)
    );

    typedef struct {
        string       tag;
        logic [63:0] v;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push(input string t, input logic [63:0] v);
        sb_t e;
        e.tag = t;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [63:0] obs);
        sb_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed %0h expected none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.v);
        end
    endtask

    task automatic exp1(input string t, input logic r, input logic d,
                        input logic p, input logic f, input logic o,
                        input logic cd, input logic [31:0] c);
        push({t, ".rstn"}, 64'(r));
        push({t, ".done"}, 64'(d));
        push({t, ".pass"}, 64'(p));
        push({t, ".fail"}, 64'(f));
        push({t, ".tmo"},  64'(o));
        push({t, ".chd"},  64'(cd));
        push({t, ".cnt"},  64'(c));
    endtask

    task automatic chk1();
        pop(64'(rstn1));
        pop(64'(done1));
        pop(64'(pass1));
        pop(64'(fail1));
        pop(64'(tmo1));
        pop(64'(chd1));
        pop(64'(cnt1));
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        en1   = 1'b1;
        addr1 = a;
        data1 = d;
    endtask

    task automatic idle1();
        en1   = 1'b0;
        addr1 = 32'h0000_1000;
        data1 = 32'h1;
    endtask

    task automatic wr4(input int ch, input logic [31:0] d);
        en4[ch]             = 1'b1;
        addr4[ch*32 +: 32]  = 32'h0000_1000;
        data4[ch*32 +: 32]  = d;
    endtask

    // Async reset check, then release and run to cycle_cnt == 0.
    task automatic reset1(input string t);
        rst1 = 1'b1;
        #1;
        exp1(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk1();
        cyc();
        rst1 = 1'b0;
        repeat (5) cyc();
    endtask

    initial begin
        rst1 = 1'b1;
        rst4 = 1'b1;
        idle1();
        en4   = '0;
        addr4 = '0;
        data4 = '0;
        cyc();
        cyc();

        exp1("por", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk1();

        rst1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            push($sformatf("hold%0d.rstn", k), 64'd0);
            pop(64'(rstn1));
        end
        cyc();
        exp1("run0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk1();
        cyc();
        push("run1.cnt", 64'd1);
        pop(64'(cnt1));

        repeat (19) cyc();
        push("run20.cnt", 64'd20);
        pop(64'(cnt1));
        wr1(32'h0000_1000, 32'h1);
        cyc();
        idle1();
        exp1("pass20", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd20);
        chk1();
        wr1(32'h0000_1000, 32'h7);
        repeat (3) cyc();
        idle1();
        exp1("pass_sticky", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd20);
        chk1();

        reset1("rst_a");
        repeat (3) cyc();
        wr1(32'h0000_1000, 32'h7);
        cyc();
        idle1();
        exp1("fail", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
        chk1();
        push("fail.code", 64'd3);
        pop(64'(fcode1));
        push("fail.ch", 64'd0);
        pop(64'(fch1));
        wr1(32'h0000_1000, 32'h1);
        cyc();
        idle1();
        cyc();
        exp1("fail_sticky", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3);
        chk1();

        reset1("rst_b");
        wr1(32'h0000_1004, 32'h1);
        cyc();
        wr1(32'h0000_1000, 32'h2);
        cyc();
        idle1();
        exp1("decoy", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
        chk1();
        repeat (97) cyc();
        exp1("pre_tmo", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd99);
        chk1();
        cyc();
        exp1("tmo", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd99);
        chk1();
        repeat (3) cyc();
        exp1("tmo_sticky", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd99);
        chk1();

        reset1("rst_c");
        repeat (99) cyc();
        wr1(32'h0000_1000, 32'h1);
        cyc();
        idle1();
        exp1("pass99", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd99);
        chk1();

        reset1("rst_d");
        repeat (50) cyc();
        push("mid.cnt", 64'd50);
        pop(64'(cnt1));
        #2;
        rst1 = 1'b1;
        #1;
        exp1("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk1();
        cyc();
        rst1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            push($sformatf("rehold%0d.rstn", k), 64'd0);
            pop(64'(rstn1));
        end
        cyc();
        exp1("rerun0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk1();

        rst4 = 1'b0;
        repeat (5) cyc();
        push("mc.rstn", 64'd1);
        pop(64'(rstn4));
        wr4(0, 32'h1);
        cyc();
        en4 = '0;
        wr4(2, 32'h1);
        wr4(3, 32'h1);
        cyc();
        en4 = '0;
        push("mc.chd", 64'hd);
        pop(64'(chd4));
        push("mc.pass", 64'd0);
        pop(64'(pass4));
        push("mc.done", 64'd0);
        pop(64'(done4));
        cyc();
        wr4(1, 32'h1);
        wr4(3, 32'h5);
        cyc();
        en4 = '0;
        push("mc.fail", 64'd1);
        pop(64'(fail4));
        push("mc.pass2", 64'd0);
        pop(64'(pass4));
        push("mc.fch", 64'd3);
        pop(64'(fch4));
        push("mc.fcode", 64'd2);
        pop(64'(fcode4));
        push("mc.cnt", 64'd3);
        pop(64'(cnt4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
